lookup3_stream: RTL and testbench

Streaming, variable-length Jenkins lookup3 (hashlittle-compatible) hash engine. It replaces the fixed 12-byte, fully unrolled memcached key hasher with a compact iterative core. The core accepts keys of 0 to 2^LEN_W−1 bytes as 96-bit beats with a runtime seed and a pass-through tag. It sits between the memcached header parser and the hash-table lookup stage, with valid/ready handshakes on both sides.

---
 rtl/lookup3_pkg.sv | 35 +++
 rtl/lookup3_stream_if.sv | 28 ++
 rtl/lookup3_step.sv | 42 ++++
 rtl/lookup3_stream.sv | 176 +++++++++++++++++
 tb/tb_lookup3_stream.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lookup3_pkg.sv
// Shared types, constants and helpers for the lookup3_stream hash engine.
// Byte order is selected by the LOOKUP3_LE_EN macro in lookup3_stream.
package lookup3_pkg;

    localparam logic [31:0] INIT = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE,
        MIX1,
        MIX2,
        FIN1,
        FIN2,
        OUT,
        DRAIN
    } state_t;

    typedef enum logic {
        OP_MIX,
        OP_FIN
    } op_t;

    // Register selected as the target of a sub-step; its source is the
    // register before it in the a->b->c cycle, the add operand the one after.
    localparam logic [1:0] ROLE_A = 2'd0;
    localparam logic [1:0] ROLE_B = 2'd1;
    localparam logic [1:0] ROLE_C = 2'd2;

    localparam logic [4:0] MIX_R [6] = '{5'd4, 5'd6, 5'd8, 5'd16, 5'd19, 5'd4};
    localparam logic [4:0] FIN_R [7] = '{5'd14, 5'd11, 5'd25, 5'd16, 5'd4, 5'd14, 5'd24};

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] k);
        return (x << k) | (x >> (6'd32 - {1'b0, k}));
    endfunction

endpackage

// File: rtl/lookup3_stream_if.sv
// Key-beat input and hash-result output handshake bundle for lookup3_stream.
interface lookup3_stream_if #(
    parameter int LEN_W = 8,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [95:0]      in_data;
    logic             in_last;
    logic [LEN_W-1:0] in_len;
    logic [31:0]      in_seed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_hash;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_last, in_len, in_seed, in_tag, out_ready,
        input  in_ready, out_valid, out_hash, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, in_len, in_seed, in_tag, out_ready,
        output in_ready, out_valid, out_hash, out_tag, out_err
    );
endinterface

// File: rtl/lookup3_step.sv
// One combinational lookup3 sub-step: mix form (t-=s; t^=rot(s); s+=w)
// or final form (t^=s; t-=rot(s)), with the target register chosen by tgt.
module lookup3_step
    import lookup3_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  tgt,
    input  logic [4:0]  rot,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o
);
    logic [31:0] t, s, w, t_n, s_n;

    always_comb begin
        case (tgt)
            ROLE_B:  begin t = b_i; s = a_i; w = c_i; end
            ROLE_C:  begin t = c_i; s = b_i; w = a_i; end
            default: begin t = a_i; s = c_i; w = b_i; end
        endcase

        if (op == OP_MIX) begin
            t_n = (t - s) ^ rotl32(s, rot);
            s_n = s + w;
        end else begin
            t_n = (t ^ s) - rotl32(s, rot);
            s_n = s;
        end

        a_o = a_i;
        b_o = b_i;
        c_o = c_i;
        case (tgt)
            ROLE_B:  begin b_o = t_n; a_o = s_n; end
            ROLE_C:  begin c_o = t_n; b_o = s_n; end
            default: begin a_o = t_n; c_o = s_n; end
        endcase
    end
endmodule

// File: rtl/lookup3_stream.sv
// Streaming Jenkins lookup3 (hashlittle-compatible) engine, 96-bit key beats.
// Define LOOKUP3_LE_EN for little-endian byte lanes; default is byte 0 at [31:24].
module lookup3_stream
    import lookup3_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int TAG_W = 8
) (
    input  logic CLK,
    input  logic RST_N,
    lookup3_stream_if.slave bus
);
    localparam logic [LEN_W-1:0] BLK = LEN_W'(12);

    state_t           st;
    logic [31:0]      a, b, c;
    logic [LEN_W-1:0] rem;
    logic [TAG_W-1:0] tag;
    logic             in_key, err_q, drain_q;

    logic             fire, first;
    logic [31:0]      init, a0, b0, c0;
    logic [LEN_W-1:0] r0;
    logic [95:0]      mask, din;

    op_t              op;
    logic [1:0]       tgt [4];
    logic [4:0]       rk  [4];
    logic [31:0]      ca  [5];
    logic [31:0]      cb  [5];
    logic [31:0]      cc  [5];
    logic [31:0]      nxt_a, nxt_b, nxt_c;

    assign bus.in_ready = RST_N && (st == IDLE || st == DRAIN);
    assign fire  = bus.in_valid && bus.in_ready;
    assign first = !in_key;
    assign init  = INIT + 32'(bus.in_len) + bus.in_seed;
    assign a0    = first ? init : a;
    assign b0    = first ? init : b;
    assign c0    = first ? init : c;
    assign r0    = first ? bus.in_len : rem;

    // A block with more than 12 bytes left keeps every byte; an empty key keeps none.
    always_comb begin
        mask = '0;
        for (int j = 0; j < 12; j++) begin
            if (j < int'(r0)) begin
`ifdef LOOKUP3_LE_EN
                mask[32*(j/4) + 8*(j%4) +: 8] = 8'hFF;
`else
                mask[32*(j/4) + 8*(3 - j%4) +: 8] = 8'hFF;
`endif
            end
        end
    end
    assign din = bus.in_data & mask;

    always_comb begin
        op     = OP_MIX;
        tgt[0] = ROLE_A; tgt[1] = ROLE_B; tgt[2] = ROLE_C; tgt[3] = ROLE_C;
        rk[0]  = MIX_R[0]; rk[1] = MIX_R[1]; rk[2] = MIX_R[2]; rk[3] = 5'd0;
        case (st)
            MIX2: begin
                rk[0] = MIX_R[3]; rk[1] = MIX_R[4]; rk[2] = MIX_R[5];
            end
            FIN1: begin
                op     = OP_FIN;
                tgt[0] = ROLE_C; tgt[1] = ROLE_A; tgt[2] = ROLE_B; tgt[3] = ROLE_C;
                rk[0]  = FIN_R[0]; rk[1] = FIN_R[1]; rk[2] = FIN_R[2]; rk[3] = FIN_R[3];
            end
            FIN2: begin
                op     = OP_FIN;
                rk[0]  = FIN_R[4]; rk[1] = FIN_R[5]; rk[2] = FIN_R[6];
            end
            default: ;
        endcase
    end

    assign ca[0] = a;
    assign cb[0] = b;
    assign cc[0] = c;

    for (genvar i = 0; i < 4; i++) begin : g_step
        lookup3_step u_step (
            .op  (op),
            .tgt (tgt[i]),
            .rot (rk[i]),
            .a_i (ca[i]),
            .b_i (cb[i]),
            .c_i (cc[i]),
            .a_o (ca[i+1]),
            .b_o (cb[i+1]),
            .c_o (cc[i+1])
        );
    end

    assign nxt_a = (st == FIN1) ? ca[4] : ca[3];
    assign nxt_b = (st == FIN1) ? cb[4] : cb[3];
    assign nxt_c = (st == FIN1) ? cc[4] : cc[3];

    // Hash state and key bookkeeping carry no reset; the control path qualifies them.
    always_ff @(posedge CLK) begin
        case (st)
            IDLE: begin
                if (fire) begin
                    if (first) tag <= bus.in_tag;
                    a   <= a0 + din[31:0];
                    b   <= b0 + din[63:32];
                    c   <= (bus.in_last && r0 > BLK) ? '0 : c0 + din[95:64];
                    rem <= r0 - BLK;
                end
            end
            MIX1, MIX2, FIN1, FIN2: begin
                a <= nxt_a;
                b <= nxt_b;
                c <= nxt_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st            <= IDLE;
            in_key        <= 1'b0;
            err_q         <= 1'b0;
            drain_q       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_hash  <= '0;
            bus.out_tag   <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (fire) begin
                        if (r0 > BLK) begin
                            if (bus.in_last) begin
                                st      <= OUT;
                                in_key  <= 1'b0;
                                err_q   <= 1'b1;
                                drain_q <= 1'b0;
                            end else begin
                                st      <= MIX1;
                                in_key  <= 1'b1;
                            end
                        end else begin
                            st      <= (r0 == '0) ? OUT : FIN1;
                            in_key  <= 1'b0;
                            err_q   <= !bus.in_last;
                            drain_q <= !bus.in_last;
                        end
                    end
                end
                MIX1: st <= MIX2;
                MIX2: st <= IDLE;
                FIN1: st <= FIN2;
                FIN2: st <= OUT;
                OUT: begin
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_hash  <= c;
                        bus.out_tag   <= tag;
                        bus.out_err   <= err_q;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        st            <= drain_q ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (fire && bus.in_last) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lookup3_stream.sv
// Directed bench for lookup3_stream: hashlittle vectors, timing, stalls,
// length errors with drain, and reset mid-key.
`timescale 1ns/1ps
module tb_lookup3_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lookup3_stream_if #(.LEN_W(8), .TAG_W(8)) bus ();

    lookup3_stream #(.LEN_W(8), .TAG_W(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] kb [64];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // Key word as the engine sees it, bytes at index >= lim read as zero.
    function automatic logic [31:0] getw(input int p, input int lim);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (p + i < lim) begin
`ifdef LOOKUP3_LE_EN
                w[8*i +: 8] = kb[p+i];
`else
                w[8*(3-i) +: 8] = kb[p+i];
`endif
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] model(input int len, input logic [31:0] seed);
        logic [31:0] a, b, c;
        int p, r;
        a = 32'hDEADBEEF + 32'(len) + seed;
        b = a;
        c = a;
        p = 0;
        r = len;
        while (r > 12) begin
            a += getw(p, len); b += getw(p + 4, len); c += getw(p + 8, len);
            a -= c; a ^= rl(c, 4);  c += b;
            b -= a; b ^= rl(a, 6);  a += c;
            c -= b; c ^= rl(b, 8);  b += a;
            a -= c; a ^= rl(c, 16); c += b;
            b -= a; b ^= rl(a, 19); a += c;
            c -= b; c ^= rl(b, 4);  b += a;
            r -= 12;
            p += 12;
        end
        if (r == 0) return c;
        a += getw(p, len); b += getw(p + 4, len); c += getw(p + 8, len);
        c ^= b; c -= rl(b, 14);
        a ^= c; a -= rl(c, 11);
        b ^= a; b -= rl(a, 25);
        c ^= b; c -= rl(b, 16);
        a ^= c; a -= rl(c, 4);
        b ^= a; b -= rl(a, 14);
        c ^= b; c -= rl(b, 24);
        return c;
    endfunction

    // Bytes past the key end are filled with junk so masking is exercised.
    task automatic load_key(input string s);
        for (int i = 0; i < 64; i++)
            kb[i] = (i < s.len()) ? s[i] : (8'hA5 ^ 8'(i));
    endtask

    function automatic logic [95:0] pack(input int p);
        logic [95:0] d;
        d = '0;
        for (int j = 0; j < 12; j++) begin
`ifdef LOOKUP3_LE_EN
            d[32*(j/4) + 8*(j%4) +: 8] = kb[p+j];
`else
            d[32*(j/4) + 8*(3 - j%4) +: 8] = kb[p+j];
`endif
        end
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Returns 1 ns after the accepting clock edge.
    task automatic send_beat(input logic [95:0] d, input logic last, input int len,
                             input logic [31:0] seed, input logic [7:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_len   = 8'(len);
        bus.in_seed  = seed;
        bus.in_tag   = tag;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_key(input int len, input logic [31:0] seed, input logic [7:0] tag);
        int nb;
        nb = (len == 0) ? 1 : (len + 11) / 12;
        for (int i = 0; i < nb; i++)
            send_beat(pack(12 * i), i == nb - 1, len, seed, tag);
    endtask

    task automatic get_result(input string nm, input logic [31:0] eh, input logic [7:0] et,
                              input logic ee);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_hash"}, bus.out_hash, eh);
        chk({nm, "_tag"}, 32'(bus.out_tag), 32'(et));
        chk({nm, "_err"}, 32'(bus.out_err), 32'(ee));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({nm, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp30_0, exp30_1, exp12;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_len    = '0;
        bus.in_seed   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_hash", bus.out_hash, 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1 chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Empty keys
        load_key("");
        send_beat(pack(0), 1'b1, 0, 32'd0, 8'h11);
        chk("empty_lat_n", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("empty_lat_n1", 32'(bus.out_valid), 32'd1);
        get_result("empty_s0", 32'hDEADBEEF, 8'h11, 1'b0);
        send_key(0, 32'hDEADBEEF, 8'h22);
        get_result("empty_sdb", 32'hBD5B7DDE, 8'h22, 1'b0);

        // 30-byte key, seed 0, with throughput and latency probes
        load_key("Four score and seven years ago");
`ifdef LOOKUP3_LE_EN
        exp30_0 = 32'h17770551;
        exp30_1 = 32'hCD628161;
`else
        exp30_0 = model(30, 32'd0);
        exp30_1 = model(30, 32'd1);
`endif
        for (int bt = 0; bt < 2; bt++) begin
            send_beat(pack(12 * bt), 1'b0, 30, 32'd0, 8'h33);
            chk("mix_busy0", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            chk("mix_busy1", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            chk("mix_free", 32'(bus.in_ready), 32'd1);
        end
        send_beat(pack(24), 1'b1, 30, 32'd0, 8'h33);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fin_lat_n2", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("fin_lat_n3", 32'(bus.out_valid), 32'd1);
        get_result("k30_s0", exp30_0, 8'h33, 1'b0);

        // Seed 1 with downstream stall and a competing first beat
        send_key(30, 32'd1, 8'h44);
        for (int n = 0; n < 40 && bus.out_valid !== 1'b1; n++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_len   = 8'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hash", bus.out_hash, exp30_1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        get_result("k30_s1", exp30_1, 8'h44, 1'b0);

        // in_last while more than 12 bytes remain
        send_beat(pack(0), 1'b0, 30, 32'd0, 8'h55);
        send_beat(pack(12), 1'b1, 30, 32'd0, 8'h55);
        get_result("early_last", 32'd0, 8'h55, 1'b1);

        // Final block without in_last, then two beats drained
        load_key("abcdefghijkl");
        exp12 = model(12, 32'd7);
        send_beat(pack(0), 1'b0, 12, 32'd7, 8'h66);
        get_result("late_last", exp12, 8'h66, 1'b1);
        send_beat(96'hFFFF_0000_1234, 1'b0, 5, 32'd3, 8'hEE);
        send_beat(96'h5555_AAAA_0001, 1'b1, 5, 32'd3, 8'hEE);
        load_key("Hello, world");
        send_key(12, 32'd0, 8'h77);
        get_result("post_drain", model(12, 32'd0), 8'h77, 1'b0);

        // Reset during MIX1 of a 3-beat key
        load_key("Four score and seven years ago");
        send_beat(pack(0), 1'b0, 30, 32'd0, 8'h99);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstmid_no_out", 32'(bus.out_valid), 32'd0);
        end
        load_key("user:1234567");
        send_key(12, 32'h0000_1234, 8'h88);
        get_result("after_rst", model(12, 32'h0000_1234), 8'h88, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
